cordic_vectoring: RTL

- Iterative vectoring-mode CORDIC, the inverse of the team's rotation-mode CORDIC.
- Takes a Cartesian vector (x0, y0) in signed Q16.16 and returns its magnitude and its angle atan2(y0, x0) in Q16.16 radians.
- Sits after the rotation datapath for polar recovery and round-trip checks.
- Single shared shift/add stage sequenced by an FSM, with valid/ready handshakes on input and output.

---
 rtl/cordic_vectoring.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC.
// Converts a signed Q16.16 Cartesian vector (x0, y0) into magnitude and
// atan2(y0, x0) in Q16.16 radians using one shared shift/add stage.
// One micro-rotation is done per clock and the sequence is run by a small FSM.
// ITERATIONS may be 1..16; the atan table holds 16 entries.
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   defined   : an extra COMP cycle scales the magnitude by K^-1, giving the true length.
//   undefined : no COMP state; the magnitude carries the CORDIC gain (~1.64676).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE. out_valid is high only in DONE.
// While out_valid=1 and out_ready=0, mag and angle are held constant.
// The FSM state is held in state_q for debug probing.
module cordic_vectoring #(
   parameter int ITERATIONS = 16,
   parameter int WIDTH      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] mag,
   output logic [WIDTH-1:0] angle
);

   // Two guard bits absorb quadrant negation and the CORDIC gain.
   localparam int XW = WIDTH + 2;
   // The product width covers x times the 17-bit K^-1 constant.
   localparam int PW = XW + 17;

   localparam logic signed [XW-1:0] HALF_PI = XW'(102944);
   localparam logic [3:0]           LAST_I  = 4'(ITERATIONS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_ITER = 3'd2,
      S_COMP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic signed [XW-1:0] x_q, x_d;
   logic signed [XW-1:0] y_q, y_d;
   logic signed [XW-1:0] z_q, z_d;
   logic signed [XW-1:0] x_sh, y_sh;
   logic [3:0]           i_q, i_d;
   logic                 zero_q, zero_d;
   logic [WIDTH-1:0]     mag_q, mag_d;
   logic [WIDTH-1:0]     angle_q, angle_d;
   logic                 last_iter;

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic signed [PW-1:0] K_INV = PW'(39797);
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_sc;
`endif

   // atan(2^-i) in Q16.16 radians.
   function automatic logic signed [XW-1:0] atan_lut(input logic [3:0] idx);
      logic signed [XW-1:0] v;
      case (idx)
         4'd0:    v = XW'(51472);
         4'd1:    v = XW'(30386);
         4'd2:    v = XW'(16055);
         4'd3:    v = XW'(8150);
         4'd4:    v = XW'(4091);
         4'd5:    v = XW'(2047);
         4'd6:    v = XW'(1024);
         4'd7:    v = XW'(512);
         4'd8:    v = XW'(256);
         4'd9:    v = XW'(128);
         4'd10:   v = XW'(64);
         4'd11:   v = XW'(32);
         4'd12:   v = XW'(16);
         4'd13:   v = XW'(8);
         4'd14:   v = XW'(4);
         default: v = XW'(2);
      endcase
      return v;
   endfunction

   // Clamp a signed value into the unsigned output word (negatives to 0).
   function automatic logic [WIDTH-1:0] sat_mag(input logic signed [PW-1:0] v);
      logic [WIDTH-1:0] r;
      if (v[PW-1]) begin
         r = '0;
      end else if (|v[PW-2:WIDTH]) begin
         r = '1;
      end else begin
         r = v[WIDTH-1:0];
      end
      return r;
   endfunction

   assign last_iter = (i_q == LAST_I);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid) state_d = S_PRE;
         S_PRE:  state_d = S_ITER;
         S_ITER: begin
            if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
               state_d = S_COMP;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_COMP: state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   assign mag   = mag_q;
   assign angle = angle_q;

   // Datapath next-state: capture, quadrant pre-rotation, micro-rotations, result load.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      zero_d  = zero_q;
      mag_d   = mag_q;
      angle_d = angle_q;
      x_sh    = x_q >>> i_q;
      y_sh    = y_q >>> i_q;
`ifdef CORDIC_GAIN_COMP_EN
      prod    = PW'(x_q) * K_INV;
      prod_sc = prod >>> 16;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d    = {{2{x0[WIDTH-1]}}, x0};
               y_d    = {{2{y0[WIDTH-1]}}, y0};
               z_d    = '0;
               zero_d = (x0 == '0) && (y0 == '0);
            end
         end
         S_PRE: begin
            // Fold left-half-plane vectors into the right half plane by +/-90 degrees.
            if (x_q[XW-1] && !y_q[XW-1]) begin
               x_d = y_q;
               y_d = -x_q;
               z_d = HALF_PI;
            end else if (x_q[XW-1]) begin
               x_d = -y_q;
               y_d = x_q;
               z_d = -HALF_PI;
            end
            i_d = '0;
         end
         S_ITER: begin
            // Drive y toward zero; z accumulates the rotation applied.
            if (!y_q[XW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_lut(i_q);
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_lut(i_q);
            end
            i_d = i_q + 4'd1;
`ifndef CORDIC_GAIN_COMP_EN
            if (last_iter) begin
               mag_d   = zero_q ? '0 : sat_mag(PW'(x_d));
               angle_d = zero_q ? '0 : z_d[WIDTH-1:0];
            end
`endif
         end
`ifdef CORDIC_GAIN_COMP_EN
         S_COMP: begin
            mag_d   = zero_q ? '0 : sat_mag(prod_sc);
            angle_d = zero_q ? '0 : z_q[WIDTH-1:0];
         end
`endif
         default: ;
      endcase
   end

   // Datapath registers; reset discards any in-flight vector.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         zero_q  <= 1'b0;
         mag_q   <= '0;
         angle_q <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         zero_q  <= zero_d;
         mag_q   <= mag_d;
         angle_q <= angle_d;
      end
   end

endmodule
